// File: rtl/din_pulse_sequencer.sv
// Pulse-burst driver for the toggle FSM din input: N one-cycle pulses spaced gap+2 cycles apart.
// Define SEQ_CHECK_EN to build the dout-toggle checker that drives err; otherwise err is tied low.
module din_pulse_sequencer #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    input  logic             fsm_dout,
    output logic             fsm_din,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_sent,
    output logic             err
);

    typedef enum logic [2:0] {
        WARM0,
        WARM1,
        IDLE,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] n_lat;
    logic [GAP_W-1:0] g_lat;
    logic [GAP_W:0]   gap_cnt;
    logic             accept;
    logic             gap_last;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        gap_last   = (gap_cnt == {1'b0, g_lat});
        case (state)
            WARM0: next_state = WARM1;
            WARM1: next_state = IDLE;
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = (num_pulses == '0) ? DONE : PULSE;
                end
            end
            PULSE: next_state = abort ? IDLE : GAP;
            GAP: begin
                if (abort)
                    next_state = IDLE;
                else if (gap_last)
                    next_state = (pulses_sent < n_lat) ? PULSE : DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state so every one of them comes straight off a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WARM0;
            fsm_din     <= 1'b0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulses_sent <= '0;
            n_lat       <= '0;
            g_lat       <= '0;
            gap_cnt     <= '0;
        end else begin
            state   <= next_state;
            fsm_din <= (next_state == PULSE);
            ready   <= (next_state == IDLE);
            busy    <= (next_state == PULSE) || (next_state == GAP) || (next_state == DONE);
            done    <= (next_state == DONE);

            if (accept) begin
                n_lat       <= num_pulses;
                g_lat       <= gap;
                pulses_sent <= '0;
            end else if (state == PULSE && !abort) begin
                pulses_sent <= pulses_sent + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            if (state == GAP && !gap_last)
                gap_cnt <= gap_cnt + {{GAP_W{1'b0}}, 1'b1};
            else
                gap_cnt <= '0;
        end
    end

`ifdef SEQ_CHECK_EN
    logic exp_level;

    // The toggle FSM flips on the edge that samples din, so the first GAP cycle sees the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_level <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            exp_level <= fsm_dout;
            err       <= 1'b0;
        end else if (state == PULSE) begin
            exp_level <= ~exp_level;
        end else if (state == GAP && gap_cnt == '0 && !abort && fsm_dout != exp_level) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_fsm_dout;

    assign unused_fsm_dout = fsm_dout;
    assign err             = 1'b0;
`endif

endmodule
